// File: rtl/universal_shift_register.sv
// Universal shift register: hold / shift right / shift left / parallel load, chosen per clock by mode.
// Optional build macro USR_SERIAL_OUT_EN adds the serial_out_msb / serial_out_lsb chaining taps.
module universal_shift_register #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       mode,
    input  logic             serial_in_right,
    input  logic             serial_in_left,
    output logic [WIDTH-1:0] data_out
`ifdef USR_SERIAL_OUT_EN
    ,
    output logic             serial_out_msb,
    output logic             serial_out_lsb
`endif
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHR   = 2'b01;
    localparam logic [1:0] MODE_SHL   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] r_q;

    // Register update: reset wins over every mode; unknown mode codes hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= {WIDTH{1'b0}};
        end else begin
            case (mode)
                MODE_HOLD: r_q <= r_q;
                MODE_SHR:  r_q <= {serial_in_left, r_q[WIDTH-1:1]};
                MODE_SHL:  r_q <= {r_q[WIDTH-2:0], serial_in_right};
                MODE_LOAD: r_q <= data_in;
                default:   r_q <= r_q;
            endcase
        end
    end

    assign data_out = r_q;

`ifdef USR_SERIAL_OUT_EN
    // End-bit taps come straight off the flops, so they reset with the register.
    assign serial_out_msb = r_q[WIDTH-1];
    assign serial_out_lsb = r_q[0];
`else
    // Without the taps, chaining uses data_out[WIDTH-1] / data_out[0] directly.
`endif

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench for universal_shift_register (WIDTH=4): a driver queues the hand-computed
// expected value for each edge and a monitor pops and compares after every rising edge.
module tb_universal_shift_register;

    logic       clk;
    logic       reset;
    logic [3:0] data_in;
    logic [1:0] mode;
    logic       serial_in_right;
    logic       serial_in_left;
    logic [3:0] data_out;
`ifdef USR_SERIAL_OUT_EN
    logic       serial_out_msb;
    logic       serial_out_lsb;
`endif

    typedef struct {
        logic [3:0] q;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   checks;
    int   errors;

    universal_shift_register #(.WIDTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .data_in         (data_in),
        .mode            (mode),
        .serial_in_right (serial_in_right),
        .serial_in_left  (serial_in_left),
        .data_out        (data_out)
`ifdef USR_SERIAL_OUT_EN
        ,
        .serial_out_msb  (serial_out_msb),
        .serial_out_lsb  (serial_out_lsb)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs on the falling edge and queue what data_out must show after the next rising edge.
    task automatic step(input logic rst, input logic [1:0] md, input logic [3:0] d,
                        input logic sil, input logic sir, input logic [3:0] exp_q, input string name);
        @(negedge clk);
        reset           = rst;
        mode            = md;
        data_in         = d;
        serial_in_left  = sil;
        serial_in_right = sir;
        sb_q.push_back('{q: exp_q, name: name});
    endtask

    // Monitor: the register presents a new value after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (data_out !== e.q) begin
                    errors++;
                    $display("FAIL %s: data_out=%b expected=%b", e.name, data_out, e.q);
                end
`ifdef USR_SERIAL_OUT_EN
                checks++;
                if (serial_out_msb !== e.q[3] || serial_out_lsb !== e.q[0]) begin
                    errors++;
                    $display("FAIL %s taps: msb=%b lsb=%b expected msb=%b lsb=%b",
                             e.name, serial_out_msb, serial_out_lsb, e.q[3], e.q[0]);
                end
`endif
            end
        end
    end

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b0;
        mode            = 2'b00;
        data_in         = 4'b0000;
        serial_in_left  = 1'b0;
        serial_in_right = 1'b0;

        // Reset beats a simultaneous parallel load.
        step(1'b0, 2'b11, 4'b1111, 1'b0, 1'b0, 4'b0000, "reset_over_load");

        // Load / shift sequence.
        step(1'b1, 2'b11, 4'b1010, 1'b0, 1'b0, 4'b1010, "seq_load_1010");
        step(1'b1, 2'b10, 4'b0000, 1'b0, 1'b1, 4'b0101, "seq_shl_sir1");
        step(1'b1, 2'b01, 4'b1111, 1'b0, 1'b1, 4'b0010, "seq_shr_sil0");
        step(1'b1, 2'b00, 4'b1111, 1'b1, 1'b1, 4'b0010, "seq_hold");
        step(1'b1, 2'b10, 4'b0000, 1'b0, 1'b1, 4'b0101, "seq_shl_sir1_b");
        step(1'b1, 2'b11, 4'b1100, 1'b0, 1'b0, 4'b1100, "seq_load_1100");

        // Shift-right fill from zero, then drain a zero back in.
        step(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 4'b0000, "fill_reset");
        step(1'b1, 2'b01, 4'b0000, 1'b1, 1'b0, 4'b1000, "fill_1");
        step(1'b1, 2'b01, 4'b1111, 1'b1, 1'b1, 4'b1100, "fill_2");
        step(1'b1, 2'b01, 4'b0000, 1'b1, 1'b0, 4'b1110, "fill_3");
        step(1'b1, 2'b01, 4'b0101, 1'b1, 1'b1, 4'b1111, "fill_4");
        step(1'b1, 2'b01, 4'b0000, 1'b0, 1'b0, 4'b0111, "fill_sil0");

        // Shift-left drop-out: MSB is discarded, serial_in_left has no effect.
        step(1'b1, 2'b11, 4'b1001, 1'b0, 1'b0, 4'b1001, "drop_load_1001");
        step(1'b1, 2'b10, 4'b1111, 1'b1, 1'b0, 4'b0010, "drop_shl_1");
        step(1'b1, 2'b10, 4'b1111, 1'b0, 1'b0, 4'b0100, "drop_shl_2");
        step(1'b1, 2'b10, 4'b0000, 1'b1, 1'b0, 4'b1000, "drop_shl_3");
        step(1'b1, 2'b10, 4'b0000, 1'b1, 1'b0, 4'b0000, "drop_shl_4");

        // Hold stability with all other inputs toggling.
        step(1'b1, 2'b11, 4'b0110, 1'b0, 1'b0, 4'b0110, "hold_load_0110");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'b00, (i % 2 == 0) ? 4'b1001 : 4'b1111,
                 i[0], ~i[0], 4'b0110, $sformatf("hold_%0d", i));
        end

        // Mid-operation reset, then release straight into a load.
        step(1'b1, 2'b11, 4'b1010, 1'b0, 1'b0, 4'b1010, "mid_load_1010");
        step(1'b1, 2'b01, 4'b0000, 1'b1, 1'b0, 4'b1101, "mid_shr_sil1");
        step(1'b1, 2'b10, 4'b0000, 1'b1, 1'b0, 4'b1010, "mid_shl_sir0");
        step(1'b0, 2'b10, 4'b1111, 1'b1, 1'b1, 4'b0000, "mid_reset");
        step(1'b1, 2'b11, 4'b0011, 1'b0, 1'b0, 4'b0011, "mid_release_load");

        // Let the monitor drain, then confirm every expectation was consumed.
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
